// File: rtl/draw_arbiter.sv
// draw_arbiter
//   Round-robin arbiter that hands the single VGA pixel-write port to one of
//   three drawing engines (bit0 platform, bit1 ball, bit2 bricks). The owner
//   gets a one-cycle draw pulse, then streams pixels through a registered mux
//   until it signals done or a cycle budget expires.
//
// Handshake: a requester raises req[i] and waits for grant[i]. draw[i] pulses
//   in the first granted cycle. While grant[i] is high, the requester's
//   x/y/colour/wren slices are forwarded to vga_* one cycle later. The
//   requester ends ownership by raising done[i]; a wren pulse in that same
//   cycle is still forwarded. Requests, strobes and done from non-owners are
//   ignored while the port is owned.
//
// Ports
//   clk, resetn               clock, asynchronous active-low reset
//   req[2:0], done[2:0]       per-requester request / drawing-finished
//   x_in[29:0], y_in[29:0]    per-requester pixel coordinates (10 bits each)
//   colour_in[8:0]            per-requester colour (3 bits each)
//   wren_in[2:0]              per-requester pixel-write strobe
//   grant[2:0], draw[2:0]     one-hot ownership and start pulse
//   vga_x, vga_y, vga_colour,
//   vga_plot                  registered pixel write to the VGA adapter
//   busy                      high whenever the FSM is not idle
//   timeout_err               sticky: an owner was forcibly released
//   dbg_state[1:0]            current FSM state encoding
module draw_arbiter #(
  parameter logic [9:0] TIMEOUT_CYCLES = 10'd1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [29:0] x_in,
  input  logic [29:0] y_in,
  input  logic [8:0]  colour_in,
  input  logic [2:0]  wren_in,
  output logic [2:0]  grant,
  output logic [2:0]  draw,
  output logic [9:0]  vga_x,
  output logic [9:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_owner;
  logic [1:0]  r_last;
  logic [9:0]  r_cnt;
  logic [9:0]  r_vga_x;
  logic [9:0]  r_vga_y;
  logic [2:0]  r_vga_colour;
  logic        r_vga_plot;
  logic        r_timeout_err;

  logic [1:0]  w_winner;
  logic [9:0]  w_own_x;
  logic [9:0]  w_own_y;
  logic [2:0]  w_own_colour;
  logic        w_own_wren;
  logic        w_own_done;
  logic        w_timeout;
  logic        w_owned;
  logic [2:0]  w_onehot;

  // Round-robin: search starts just after the most recently released owner.
  always_comb begin
    w_winner = 2'd0;
    case (r_last)
      2'd0: begin
        if (req[1])      w_winner = 2'd1;
        else if (req[2]) w_winner = 2'd2;
        else             w_winner = 2'd0;
      end
      2'd1: begin
        if (req[2])      w_winner = 2'd2;
        else if (req[0]) w_winner = 2'd0;
        else             w_winner = 2'd1;
      end
      default: begin
        if (req[0])      w_winner = 2'd0;
        else if (req[1]) w_winner = 2'd1;
        else             w_winner = 2'd2;
      end
    endcase
  end

  // Owner slice mux; only the owner's signals ever reach the VGA port or FSM.
  always_comb begin
    w_own_x      = x_in[9:0];
    w_own_y      = y_in[9:0];
    w_own_colour = colour_in[2:0];
    w_own_wren   = wren_in[0];
    w_own_done   = done[0];
    case (r_owner)
      2'd1: begin
        w_own_x      = x_in[19:10];
        w_own_y      = y_in[19:10];
        w_own_colour = colour_in[5:3];
        w_own_wren   = wren_in[1];
        w_own_done   = done[1];
      end
      2'd2: begin
        w_own_x      = x_in[29:20];
        w_own_y      = y_in[29:20];
        w_own_colour = colour_in[8:6];
        w_own_wren   = wren_in[2];
        w_own_done   = done[2];
      end
      default: ;
    endcase
  end

  // Next state. r_cnt counts completed ACTIVE cycles, so the ACTIVE cycle in
  // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE:    if (|req) w_next_state = START;
      START:   w_next_state = ACTIVE;
      ACTIVE: begin
        if (w_own_done) begin
          w_next_state = RELEASE;
        end else if (r_cnt == TIMEOUT_CYCLES - 10'd1) begin
          w_next_state = RELEASE;
          w_timeout    = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_owner       <= 2'd0;
      r_last        <= 2'd2;
      r_cnt         <= 10'd0;
      r_vga_x       <= 10'd0;
      r_vga_y       <= 10'd0;
      r_vga_colour  <= 3'd0;
      r_vga_plot    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && |req) begin
        r_owner <= w_winner;
        r_cnt   <= 10'd0;
      end else if (r_state == ACTIVE) begin
        r_cnt <= r_cnt + 10'd1;
      end
      if (r_state == RELEASE) r_last <= r_owner;
      if (w_timeout) r_timeout_err <= 1'b1;
      // Coordinates load every owned cycle; they hold while unowned.
      if (w_owned) begin
        r_vga_x      <= w_own_x;
        r_vga_y      <= w_own_y;
        r_vga_colour <= w_own_colour;
        r_vga_plot   <= w_own_wren;
      end else begin
        r_vga_plot   <= 1'b0;
      end
    end
  end

  assign w_owned     = (r_state == START) || (r_state == ACTIVE);
  assign w_onehot    = 3'b001 << r_owner;
  assign grant       = w_owned ? w_onehot : 3'b000;
  assign draw        = (r_state == START) ? w_onehot : 3'b000;
  assign busy        = (r_state != IDLE);
  assign vga_x       = r_vga_x;
  assign vga_y       = r_vga_y;
  assign vga_colour  = r_vga_colour;
  assign vga_plot    = r_vga_plot;
  assign timeout_err = r_timeout_err;
  assign dbg_state   = r_state;

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 10'd1023: maximum ACTIVE cycles before a forced release.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req  input  3  draw request per requester; bit0 platform, bit1 ball, bit2 bricks.
REQ-005 done  input  3  per-requester "drawing finished" level/pulse; sampled only for current owner.
REQ-006 x_in  input  30  requester pixel x, 10 bits each; requester i at [10i+9:10i].
REQ-007 y_in  input  30  requester pixel y, 10 bits each, same packing.
REQ-008 colour_in  input  9  requester colour, 3 bits each; requester i at [3i+2:3i].
REQ-009 wren_in  input  3  requester pixel-write strobe.
REQ-010 grant  output  3  one-hot ownership of the VGA write port; all zero when unowned.
REQ-011 draw  output  3  one-cycle start pulse to the granted requester.
REQ-012 vga_x  output  10  registered pixel x to the VGA adapter.
REQ-013 vga_y  output  10  registered pixel y to the VGA adapter.
REQ-014 vga_colour  output  3  registered pixel colour.
REQ-015 vga_plot  output  1  registered write enable to the VGA adapter.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  sticky flag: a forced release has occurred.

Function
REQ-018 FSM states SHALL be IDLE, START, ACTIVE, RELEASE; 2-bit encoding.
REQ-019 IDLE: req==0 -> stay; otherwise latch the round-robin winner into owner and go to START.
REQ-020 Round-robin: search order begins at (last+1) mod 3 and wraps; last is the most recently released owner.
REQ-021 START: grant[owner]=1 and draw[owner]=1 for exactly one cycle; next state ACTIVE.
REQ-022 ACTIVE: grant[owner]=1 and draw=0; stay until done[owner]=1 or the timeout counter reaches TIMEOUT_CYCLES.
REQ-023 RELEASE: grant=0 for one cycle; last<=owner; next state IDLE, so a new START comes no sooner than 2 cycles after done.
REQ-024 Pixel mux: in START and ACTIVE, vga_x/vga_y/vga_colour/vga_plot SHALL load the owner's x_in/y_in/colour_in/wren_in slices on the next edge, giving one-cycle latency.
REQ-025 In IDLE and RELEASE, vga_plot SHALL be registered 0; vga_x/vga_y/vga_colour hold their last values.
REQ-026 A wren_in[owner] pulse in the same cycle as done[owner] SHALL still be forwarded, so vga_plot=1 in the RELEASE-entry cycle.
REQ-027 wren_in, done and req of non-owners SHALL be ignored while owned; deasserting req[owner] during ACTIVE SHALL NOT end ownership.
REQ-028 Timeout counter: 10-bit, cleared on entry to START, increments each ACTIVE cycle.
REQ-029 Reaching TIMEOUT_CYCLES in ACTIVE SHALL force RELEASE and set timeout_err; the flag clears only on reset.
REQ-030 grant SHALL never have more than one bit set; draw SHALL be a subset of grant.

Reset
REQ-031 resetn low SHALL immediately, without a clock, force state=IDLE, owner=0, last=2 (first priority is platform), and counter=0.
REQ-032 resetn low SHALL immediately force grant=0, draw=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0 and timeout_err=0.
REQ-033 Reset asserted mid-ACTIVE SHALL abort the transaction with no further vga_plot; after release, the first arbitration again favours bit0.

Verification
REQ-034 The bench SHALL cover a single request: req=3'b010 after reset -> START at cycle 1 with grant=010 and draw=010; ACTIVE from cycle 2; ball pixel (5,7,3'b001, wren=1) appears on vga_* with plot=1 one cycle later.
REQ-035 The bench SHALL cover simultaneous requests: req=3'b111 held, each owner asserts done after 4 ACTIVE cycles -> grant order 001,010,100,001, with a RELEASE cycle of grant=000 between each.
REQ-036 The bench SHALL cover done plus a final pixel in the same cycle: platform asserts wren and done together with x=40 -> vga_x=40 and vga_plot=1 on the next cycle; vga_plot=0 the cycle after.
REQ-037 The bench SHALL cover timeout: the owner never asserts done, with TIMEOUT_CYCLES=1023 -> forced RELEASE after 1023 ACTIVE cycles, timeout_err=1, and the flag remains 1 through later grants.
REQ-038 The bench SHALL cover reset mid-operation: resetn pulled low mid-ACTIVE between clock edges -> grant=000, vga_plot=0 and busy=0 before the next edge; after release with req=111, the first grant is 001.
REQ-039 The bench SHALL cover non-owner isolation: bricks owns and ball toggles wren_in, done and req -> no change to vga_* from the ball slice, and ownership is unchanged.
